mips_bus_master: RTL and testbench
==================================

// Module: mips_bus_master
// PURPOSE
//  Initiator end of the CPU memory bus: accepts one load/store request at a time from the core,
//  drives address/read/write/writedata/byteenable to the memory slave, and holds them while
//  waitrequest is high. Returns read data or completion to the core as a 1-cycle response pulse.
//  Sits between the MIPS core's fetch/LSU arbiter and the RAM / slave model.
// PARAMETERS
//  READ_LATENCY    1    cycles from the read/waitrequest=0 edge to valid readdata (0 or 1 only)
//  TIMEOUT_CYCLES  64   consecutive waitrequest=1 cycles before a transfer is abandoned (>=2)
// PORTS
//  clk             in   1   system clock, all logic on posedge
//  reset           in   1   synchronous, active-high
//  req_valid       in   1   core request present
//  req_ready       out  1   block can accept a request this cycle
//  req_write       in   1   1=store, 0=load
//  req_address     in   32  byte address, must be word aligned
//  req_writedata   in   32  store data
//  req_byteenable  in   4   store byte lanes (loads always drive 4'hF)
//  resp_valid      out  1   1-cycle pulse: request complete
//  resp_readdata   out  32  load data, valid with resp_valid
//  resp_error      out  1   valid with resp_valid: misaligned or timed out
//  address         out  32  bus address
//  read            out  1   bus read strobe
//  write           out  1   bus write strobe
//  writedata       out  32  bus write data
//  byteenable      out  4   bus byte lanes
//  readdata        in   32  bus read data
//  waitrequest     in   1   slave stall
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; read=write=0; address=writedata=0; byteenable=0;
//   resp_valid=resp_error=0; resp_readdata=0; timeout counter=0. Reset overrides any transfer.
//   read/write go low at the reset edge with no response issued.
//  req_ready = (state==IDLE) && !reset; combinational. A request is taken when req_valid&&req_ready.
//  FSM:
//   IDLE:   on accept, if req_address[1:0]!=0 -> RESP with error=1, no bus cycle. Otherwise register
//           address/writedata/byteenable (4'hF for loads) and assert read or write -> BUS.
//   BUS:    strobe and all bus outputs held stable. Counter increments each cycle waitrequest=1.
//           waitrequest=0: write -> drop strobe, RESP. Read with READ_LATENCY=0 -> capture
//           readdata this edge, RESP. Read with READ_LATENCY=1 -> drop read, RDWAIT.
//           Counter reaching TIMEOUT_CYCLES-1 with waitrequest=1 -> drop strobe, RESP with error=1.
//   RDWAIT: read=0; capture readdata at this edge -> RESP.
//   RESP:   resp_valid=1 for exactly one cycle, then IDLE. resp_readdata holds its last value
//           until the next load completes. resp_error=0 except as above. Counter cleared.
//  read and write never both high. Strobes are registered outputs. Slave may hold waitrequest=0
//   before or during the strobe's first cycle; the block samples waitrequest only in BUS.
//  Latency (waitrequest never high): store accepted at edge N -> resp_valid in cycle N+2.
//   Load: N+2 (READ_LATENCY=0) or N+3 (READ_LATENCY=1). Each stall cycle adds one.
//   Misaligned request: resp_valid in cycle N+1.
//  Back-to-back requests: next accept is in the IDLE cycle after RESP. No pipelining.
//  Inputs req_* are ignored outside IDLE. Changes to readdata outside the capture edge are ignored.
// TESTING
//  1 Store 0xBFC00010 data 0xDEADBEEF be 4'hF, waitrequest=0 -> one write cycle with that
//    address/data, resp_valid at N+2, resp_error=0.
//  2 Load 0xBFC00010, READ_LATENCY=1, slave returns 0xDEADBEEF one cycle later ->
//    resp_readdata=0xDEADBEEF at N+3. read high exactly 1 cycle.
//  3 Load 0xBFC00004, waitrequest high 5 cycles -> read/address stable all 6 BUS cycles,
//    resp_valid at N+8 (latency 1).
//  4 Load 0xBFC00002 -> no read strobe, resp_valid at N+1, resp_error=1.
//  5 Store, waitrequest stuck high, TIMEOUT_CYCLES=4 -> write drops after 4 BUS cycles,
//    resp_error=1, block returns to IDLE and accepts the next request.
//  6 reset asserted while in BUS with waitrequest=1 -> next cycle read=write=0, no resp_valid,
//    req_ready=1 after reset is released.

Source files
------------

// File: rtl/mips_bus_master.sv
// Initiator side of the CPU memory bus. It takes one load/store from the core at a time,
// holds the bus signals through slave stalls, and returns a one-cycle response.
module mips_bus_master #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_writedata,
  input  logic [3:0]  req_byteenable,
  output logic        resp_valid,
  output logic [31:0] resp_readdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUS, RDWAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   address_q;
  logic [31:0]   writedata_q;
  logic [3:0]    byteenable_q;
  logic          read_q;
  logic          write_q;
  logic          resp_valid_q;
  logic          resp_error_q;
  logic [31:0]   resp_readdata_q;

  assign req_ready     = (state_q == IDLE) && !reset;
  assign address       = address_q;
  assign writedata     = writedata_q;
  assign byteenable    = byteenable_q;
  assign read          = read_q;
  assign write         = write_q;
  assign resp_valid    = resp_valid_q;
  assign resp_error    = resp_error_q;
  assign resp_readdata = resp_readdata_q;

  // NOTE: state is updated with non-blocking assignments only, so every branch below
  // reads the pre-edge values and the order of statements never matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      address_q       <= '0;
      writedata_q     <= '0;
      byteenable_q    <= '0;
      read_q          <= 1'b0;
      write_q         <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_error_q    <= 1'b0;
      resp_readdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_address[1:0] != 2'b00) begin
              // Misaligned: answer with an error without touching the bus.
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              address_q    <= req_address;
              writedata_q  <= req_writedata;
              byteenable_q <= req_write ? req_byteenable : 4'hF;
              read_q       <= !req_write;
              write_q      <= req_write;
              cnt_q        <= '0;
              state_q      <= BUS;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (write_q) begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else if (READ_LATENCY == 0) begin
              resp_readdata_q <= readdata;
              resp_valid_q    <= 1'b1;
              state_q         <= RESP;
            end else begin
              state_q <= RDWAIT;
            end
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RDWAIT: begin
          resp_readdata_q <= readdata;
          resp_valid_q    <= 1'b1;
          state_q         <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          cnt_q        <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_master.sv
// Directed bench for mips_bus_master: instance A (read latency 1, long timeout) and
// instance B (read latency 0, timeout 4), each with hand-computed expectations.
module tb_mips_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_writedata;
  logic [3:0]  req_byteenable;
  logic [31:0] rdata;
  logic        rv_a, rv_b, wr_a, wr_b;

  logic        rdy_a, rvld_a, rerr_a, rd_a, wrs_a;
  logic [31:0] rdat_a, addr_a, wdat_a;
  logic [3:0]  be_a;
  logic        rdy_b, rvld_b, rerr_b, rd_b, wrs_b;
  logic [31:0] rdat_b, addr_b, wdat_b;
  logic [3:0]  be_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_bus_master #(.READ_LATENCY(1), .TIMEOUT_CYCLES(64)) dut_a (
    .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(rdy_a), .req_write(req_write),
    .req_address(req_address), .req_writedata(req_writedata), .req_byteenable(req_byteenable),
    .resp_valid(rvld_a), .resp_readdata(rdat_a), .resp_error(rerr_a), .address(addr_a),
    .read(rd_a), .write(wrs_a), .writedata(wdat_a), .byteenable(be_a), .readdata(rdata),
    .waitrequest(wr_a)
  );

  mips_bus_master #(.READ_LATENCY(0), .TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(rdy_b), .req_write(req_write),
    .req_address(req_address), .req_writedata(req_writedata), .req_byteenable(req_byteenable),
    .resp_valid(rvld_b), .resp_readdata(rdat_b), .resp_error(rerr_b), .address(addr_b),
    .read(rd_b), .write(wrs_b), .writedata(wdat_b), .byteenable(be_b), .readdata(rdata),
    .waitrequest(wr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge, when registers have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    req_write      = w;
    req_address    = a;
    req_writedata  = d;
    req_byteenable = be;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rv_a = 1'b0; rv_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    rdata = 32'h1111_1111;
    set_req(1'b0, 32'h0, 32'h0, 4'h0);
    step(); step();
    check("reset_ready", {31'b0, rdy_a}, 32'd0);
    check("reset_strobes", {30'b0, rd_a, wrs_a}, 32'd0);
    check("reset_resp", {30'b0, rvld_a, rerr_a}, 32'd0);
    check("reset_addr", addr_a, 32'h0);
    check("reset_be", {28'b0, be_a}, 32'h0);
    check("reset_rdata", rdat_a, 32'h0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'b0, rdy_a}, 32'd1);

    // 1: store, no stall; response seen in cycle N+2.
    set_req(1'b1, 32'hBFC0_0010, 32'hDEAD_BEEF, 4'hF);
    rv_a = 1'b1; step(); rv_a = 1'b0;
    check("t1_write", {30'b0, rd_a, wrs_a}, 32'd1);
    check("t1_addr", addr_a, 32'hBFC0_0010);
    check("t1_wdata", wdat_a, 32'hDEAD_BEEF);
    check("t1_be", {28'b0, be_a}, 32'hF);
    check("t1_ready_busy", {31'b0, rdy_a}, 32'd0);
    step();
    check("t1_strobe_drop", {30'b0, rd_a, wrs_a}, 32'd0);
    check("t1_resp", {30'b0, rvld_a, rerr_a}, 32'b10);
    check("t1_rdata_held", rdat_a, 32'h0);
    step();
    check("t1_resp_pulse", {31'b0, rvld_a}, 32'd0);
    check("t1_idle_ready", {31'b0, rdy_a}, 32'd1);

    // 2: load, latency 1; readdata only valid at the capture edge.
    set_req(1'b0, 32'hBFC0_0010, 32'h5555_5555, 4'h0);
    rdata = 32'h1111_1111;
    rv_a = 1'b1; step(); rv_a = 1'b0;
    check("t2_read", {30'b0, rd_a, wrs_a}, 32'd2);
    check("t2_be_load", {28'b0, be_a}, 32'hF);
    step();
    rdata = 32'hDEAD_BEEF;
    check("t2_read_1cycle", {31'b0, rd_a}, 32'd0);
    check("t2_no_resp_yet", {31'b0, rvld_a}, 32'd0);
    step();
    check("t2_resp", {30'b0, rvld_a, rerr_a}, 32'b10);
    check("t2_rdata", rdat_a, 32'hDEAD_BEEF);
    step();

    // 3: load with 5 stall cycles; response in cycle N+8.
    set_req(1'b0, 32'hBFC0_0004, 32'h0, 4'hF);
    rdata = 32'h1357_9BDF;
    wr_a = 1'b1;
    rv_a = 1'b1; step(); rv_a = 1'b0;
    set_req(1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'h1);
    for (int i = 0; i < 5; i++) begin
      check("t3_read_held", {31'b0, rd_a}, 32'd1);
      check("t3_addr_held", addr_a, 32'hBFC0_0004);
      check("t3_no_resp", {31'b0, rvld_a}, 32'd0);
      step();
    end
    wr_a = 1'b0;
    check("t3_read_6th", {31'b0, rd_a}, 32'd1);
    check("t3_addr_6th", addr_a, 32'hBFC0_0004);
    step();
    check("t3_rdwait", {30'b0, rvld_a, rd_a}, 32'd0);
    step();
    check("t3_resp", {30'b0, rvld_a, rerr_a}, 32'b10);
    check("t3_rdata", rdat_a, 32'h1357_9BDF);
    step();

    // 4: misaligned load; error response in cycle N+1 with no bus cycle.
    set_req(1'b0, 32'hBFC0_0002, 32'h0, 4'hF);
    rv_a = 1'b1; step(); rv_a = 1'b0;
    check("t4_no_strobe", {30'b0, rd_a, wrs_a}, 32'd0);
    check("t4_resp_err", {30'b0, rvld_a, rerr_a}, 32'b11);
    check("t4_rdata_kept", rdat_a, 32'h1357_9BDF);
    step();
    check("t4_err_clear", {30'b0, rvld_a, rerr_a}, 32'd0);

    // 5: store with waitrequest stuck high on B (timeout 4).
    set_req(1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 4'hF);
    wr_b = 1'b1;
    rv_b = 1'b1; step(); rv_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_write_held", {31'b0, wrs_b}, 32'd1);
      step();
    end
    check("t5_write_drop", {31'b0, wrs_b}, 32'd0);
    check("t5_resp_err", {30'b0, rvld_b, rerr_b}, 32'b11);
    step();
    check("t5_ready", {31'b0, rdy_b}, 32'd1);
    wr_b = 1'b0;
    set_req(1'b1, 32'h0000_0044, 32'h0BAD_CAFE, 4'h3);
    rv_b = 1'b1; step(); rv_b = 1'b0;
    check("t5_next_write", {30'b0, rd_b, wrs_b}, 32'd1);
    check("t5_next_be", {28'b0, be_b}, 32'h3);
    check("t5_next_wdata", wdat_b, 32'h0BAD_CAFE);
    step();
    check("t5_next_resp", {30'b0, rvld_b, rerr_b}, 32'b10);
    step();

    // Load on B with read latency 0: readdata captured at the BUS edge.
    set_req(1'b0, 32'h0000_0080, 32'h0, 4'h0);
    rdata = 32'hCAFE_F00D;
    rv_b = 1'b1; step(); rv_b = 1'b0;
    check("b_read", {30'b0, rd_b, wrs_b}, 32'd2);
    step();
    rdata = 32'h2222_2222;
    check("b_resp", {30'b0, rvld_b, rerr_b}, 32'b10);
    check("b_rdata", rdat_b, 32'hCAFE_F00D);
    step();

    // 6: reset during a stalled read on A.
    set_req(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    wr_a = 1'b1;
    rv_a = 1'b1; step(); rv_a = 1'b0;
    step();
    check("t6_read_before", {31'b0, rd_a}, 32'd1);
    reset = 1'b1;
    step();
    check("t6_strobes_low", {30'b0, rd_a, wrs_a}, 32'd0);
    check("t6_no_resp", {31'b0, rvld_a}, 32'd0);
    check("t6_not_ready_in_reset", {31'b0, rdy_a}, 32'd0);
    reset = 1'b0;
    #1;
    check("t6_ready_after", {31'b0, rdy_a}, 32'd1);
    step();
    check("t6_still_no_resp", {30'b0, rvld_a, rd_a}, 32'd0);
    wr_a = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
